clk_div_multi: RTL and testbench
================================

Name: clk_div_multi

Overview:
- Multi-channel integer clock divider for generating gated, divided clocks from one reference clock.
- NUM_CH independent channels, each with its own ratio, enable and duty mode.
- Ratio and mode changes apply only at period boundaries, so no runt pulses appear during reconfiguration.
- Adds a per-channel period-boundary strobe and a busy flag for the clock-gating/sequencing logic.

Parameters:
- NUM_CH, 4, number of independent divider channels.
- RATIO_WD, 8, width of each division ratio; maximum ratio 2^RATIO_WD-1.

Ports:
- i_ref_clk  input  1  reference clock; sole clock of the block.
- i_rst  input  1  reset, synchronous, active-high.
- i_clk_en  input  NUM_CH  per-channel enable.
- i_div_ratio  input  NUM_CH*RATIO_WD  packed ratios; channel k uses bits [k*RATIO_WD +: RATIO_WD].
- i_pulse_mode  input  NUM_CH  per channel: 0 gives ~50% duty, 1 gives a single-ref-cycle high pulse per period.
- o_div_clk  output  NUM_CH  divided clocks.
- o_tick  output  NUM_CH  registered strobe, high in the first ref cycle of each divided period.
- o_busy  output  NUM_CH  channel state is not IDLE.

Behaviour:
- Per-channel state machine with states IDLE, RUN and BYPASS.
- Per-channel registers: state, cnt[RATIO_WD], act_ratio, act_mode, div_q, tick_q.
- Reset: state=IDLE; cnt, act_ratio, act_mode, div_q and tick_q all 0. Hence o_div_clk=0, o_tick=0, o_busy=0.
- Output: o_div_clk = div_q | (state==BYPASS & i_ref_clk).
- hi_len: 1 if act_mode=1, else (act_ratio+1)>>1, computed at RATIO_WD+1 bits.
  - The high phase is ceil(R/2) cycles and the low phase is floor(R/2) cycles.
- "Load" means: act_ratio<=ratio, act_mode<=mode, cnt<=0.
  - If ratio>=2: state<=RUN, div_q<=1, tick_q<=1.
  - If ratio<2 (values 0 and 1): state<=BYPASS, div_q<=0, tick_q<=1.
- IDLE:
  - en=1: load on the next edge. The first divided high phase starts one ref cycle after the enable is sampled.
  - en=0: stay in IDLE; div_q=0, tick_q=0.
- RUN, cnt!=act_ratio-1:
  - cnt<=cnt+1; div_q<=((cnt+1)<hi_len); tick_q<=0.
  - i_div_ratio, i_pulse_mode and enable changes are ignored until the boundary.
- RUN, cnt==act_ratio-1 (boundary):
  - en=1: load, so the new ratio and mode take effect for the next period.
  - en=0: state<=IDLE, div_q<=0, tick_q<=0, cnt<=0.
  - A disable therefore always completes the current period; no truncated high phase.
- BYPASS (every ref cycle is a boundary):
  - en=1 and ratio<2: stay in BYPASS, tick_q=1.
  - en=1 and ratio>=2: load into RUN.
  - en=0: go to IDLE.
  - Exit from BYPASS takes effect at a rising edge, so the last ref high phase is truncated. This is accepted and documented; downstream must not enter or exit bypass while clocking critical logic.
- Period of o_div_clk equals act_ratio ref cycles exactly. o_tick is coincident with each rising edge of div_q.
- Channels are fully independent; simultaneous events on different channels do not interact.
- i_rst mid-operation: all channels reach the reset state on the next edge, regardless of state.
- cnt never wraps: it always returns to 0 at the boundary, and act_ratio>=2 in RUN.

Decomposition:
- Shared package clk_div_pkg:
  - state enum (IDLE=2'd0, RUN=2'd1, BYPASS=2'd2);
  - function ceil_half(ratio) returning the (RATIO_WD+1)-bit result.
- Sub-module clk_div_chan: one channel with its state machine, counter and output mux, parametrised by RATIO_WD.
- clk_div_multi: a generate loop of NUM_CH clk_div_chan instances, plus packed-port slicing.

Test Plan:
1. Ch0 ratio=4, mode=0, en rises at cycle 10.
   - Expect div_clk 1,1,0,0 repeating from cycle 11.
   - Expect o_tick at cycles 11, 15, 19; o_busy=1 from cycle 11.
2. Ch1 ratio=5, mode=0 -> high 3 / low 2, period 5; ratio=255 -> high 128 / low 127.
3. Ch0 running ratio=4; change ratio to 6 at cnt=1.
   - Current period still lasts 4 cycles; the next periods are 6 (high 3 / low 3).
   - Tick spacing goes 4 then 6.
4. Ch2 ratio=6; drop en at cnt=2.
   - Output completes the 3 high / 3 low period, then stays 0.
   - o_busy falls after cnt=5; no tick afterwards.
5. Ch3 ratio=1, then ratio=0, en=1.
   - o_div_clk follows i_ref_clk; o_tick stays 1.
   - Change ratio to 3 -> RUN with period 3 from the next edge.
6. All channels running, ratio=3, mode=1: high 1 / low 2. Assert i_rst for one cycle mid-period.
   - All outputs are 0 after that edge; re-enabling restarts at cnt=0.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the multi-channel clock divider.
// Channel state encoding is fixed so debug probes can decode it directly.
package clk_div_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRun    = 2'd1,
        StBypass = 2'd2
    } chan_state_e;

    // Length of the high phase for a ~50% duty period: ceil(ratio/2).
    function automatic logic [31:0] ceil_half(input logic [31:0] ratio);
        return (ratio + 32'd1) >> 1;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: ratio/mode are latched only at period boundaries so a
// reconfiguration never produces a runt pulse on the divided clock.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int unsigned RATIO_WD = 8
) (
    input  logic                i_ref_clk,
    input  logic                i_rst,
    input  logic                i_en,
    input  logic [RATIO_WD-1:0] i_ratio,
    input  logic                i_mode,
    output logic                o_div_clk,
    output logic                o_tick,
    output logic                o_busy
);

    chan_state_e         state_q, state_d;
    logic [RATIO_WD-1:0] cnt_q, cnt_d;
    logic [RATIO_WD-1:0] act_ratio_q, act_ratio_d;
    logic                act_mode_q, act_mode_d;
    logic                div_q, div_d;
    logic                tick_q, tick_d;

    logic [31:0] hi_len;
    logic        boundary;
    logic        do_load;

    assign hi_len   = act_mode_q ? 32'd1 : ceil_half(32'(act_ratio_q));
    assign boundary = (cnt_q == (act_ratio_q - RATIO_WD'(1)));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        act_ratio_d = act_ratio_q;
        act_mode_d  = act_mode_q;
        div_d       = div_q;
        tick_d      = 1'b0;
        do_load     = 1'b0;

        case (state_q)
            StIdle: begin
                if (i_en) begin
                    do_load = 1'b1;
                end else begin
                    div_d = 1'b0;
                end
            end
            StRun: begin
                if (!boundary) begin
                    cnt_d = cnt_q + RATIO_WD'(1);
                    div_d = ((32'(cnt_q) + 32'd1) < hi_len);
                end else if (i_en) begin
                    do_load = 1'b1;
                end else begin
                    state_d = StIdle;
                    div_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
            StBypass: begin
                // Every reference cycle is a boundary while bypassing.
                if (i_en) begin
                    do_load = 1'b1;
                end else begin
                    state_d = StIdle;
                    div_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = StIdle;
                div_d   = 1'b0;
                cnt_d   = '0;
            end
        endcase

        if (do_load) begin
            act_ratio_d = i_ratio;
            act_mode_d  = i_mode;
            cnt_d       = '0;
            tick_d      = 1'b1;
            if (i_ratio >= RATIO_WD'(2)) begin
                state_d = StRun;
                div_d   = 1'b1;
            end else begin
                state_d = StBypass;
                div_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge i_ref_clk) begin
        if (i_rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            act_ratio_q <= '0;
            act_mode_q  <= 1'b0;
            div_q       <= 1'b0;
            tick_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            act_ratio_q <= act_ratio_d;
            act_mode_q  <= act_mode_d;
            div_q       <= div_d;
            tick_q      <= tick_d;
        end
    end

    // Bypass passes the reference clock straight through; exit truncates its last high phase.
    assign o_div_clk = div_q | ((state_q == StBypass) & i_ref_clk);
    assign o_tick    = tick_q;
    assign o_busy    = (state_q != StIdle);

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel integer clock divider: NUM_CH independent channels sharing
// one reference clock, each with its own ratio, enable and duty mode.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned RATIO_WD = 8
) (
    input  logic                       i_ref_clk,
    input  logic                       i_rst,
    input  logic [NUM_CH-1:0]          i_clk_en,
    input  logic [NUM_CH*RATIO_WD-1:0] i_div_ratio,
    input  logic [NUM_CH-1:0]          i_pulse_mode,
    output logic [NUM_CH-1:0]          o_div_clk,
    output logic [NUM_CH-1:0]          o_tick,
    output logic [NUM_CH-1:0]          o_busy
);

    for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
        clk_div_chan #(
            .RATIO_WD(RATIO_WD)
        ) u_chan (
            .i_ref_clk(i_ref_clk),
            .i_rst    (i_rst),
            .i_en     (i_clk_en[k]),
            .i_ratio  (i_div_ratio[k*RATIO_WD +: RATIO_WD]),
            .i_mode   (i_pulse_mode[k]),
            .o_div_clk(o_div_clk[k]),
            .o_tick   (o_tick[k]),
            .o_busy   (o_busy[k])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi: directed scenarios plus randomized
// reconfiguration against a period-level behavioural model.
module tb_clk_div_multi;

    localparam int NCH = 4;
    localparam int RW  = 8;

    logic              clk;
    logic              rst;
    logic [NCH-1:0]    en;
    logic [NCH*RW-1:0] ratio;
    logic [NCH-1:0]    mode;
    logic [NCH-1:0]    o_div_clk;
    logic [NCH-1:0]    o_tick;
    logic [NCH-1:0]    o_busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: is a period in progress, is it a bypass, position within it, its length and high length.
    int m_act[NCH];
    int m_byp[NCH];
    int m_pos[NCH];
    int m_len[NCH];
    int m_hi[NCH];
    logic [NCH-1:0] exp_div, exp_tick, exp_busy;

    clk_div_multi #(
        .NUM_CH  (NCH),
        .RATIO_WD(RW)
    ) dut (
        .i_ref_clk   (clk),
        .i_rst       (rst),
        .i_clk_en    (en),
        .i_div_ratio (ratio),
        .i_pulse_mode(mode),
        .o_div_clk   (o_div_clk),
        .o_tick      (o_tick),
        .o_busy      (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance the model by one reference edge using the inputs seen at that edge.
    task automatic model_edge();
        for (int c = 0; c < NCH; c++) begin
            int r;
            r = int'(ratio[c*RW +: RW]);
            if (rst) begin
                m_act[c] = 0; m_byp[c] = 0; m_pos[c] = 0;
            end else if (m_act[c] == 0 || m_byp[c] != 0 || m_pos[c] == m_len[c] - 1) begin
                if (en[c]) begin
                    m_act[c] = 1;
                    m_pos[c] = 0;
                    m_byp[c] = (r < 2) ? 1 : 0;
                    m_len[c] = r;
                    m_hi[c]  = mode[c] ? 1 : (r + 1) / 2;
                end else begin
                    m_act[c] = 0; m_byp[c] = 0; m_pos[c] = 0;
                end
            end else begin
                m_pos[c]++;
            end
            exp_busy[c] = (m_act[c] != 0);
            exp_tick[c] = (m_act[c] != 0) && (m_pos[c] == 0);
            // Sampled just after a rising edge, so a bypassed channel reads high.
            exp_div[c]  = (m_act[c] != 0) && (m_byp[c] != 0 || m_pos[c] < m_hi[c]);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        en = '0; mode = '0; ratio = '0; rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        en = '0; mode = '0; ratio = '0; rst = 1'b1;
        cycle();
        cycle();
        n_tests++;
        if (o_div_clk !== 4'h0 || o_tick !== 4'h0 || o_busy !== 4'h0) begin
            n_fail++;
            $display("FAIL reset div=%b tick=%b busy=%b required 0000", o_div_clk, o_tick, o_busy);
        end
        rst = 1'b0;
        for (int t = 0; t < 3; t++) begin
            cycle();
            n_tests++;
            if (o_div_clk !== 4'h0 || o_tick !== 4'h0 || o_busy !== 4'h0) begin
                n_fail++;
                $display("FAIL idle t=%0d div=%b tick=%b busy=%b required 0000",
                         t, o_div_clk, o_tick, o_busy);
            end
        end
    endtask

    task automatic test_basic();
        do_reset();
        ratio[0*RW +: RW] = 8'd4;
        en[0] = 1'b1;
        for (int t = 0; t < 12; t++) begin
            cycle();
            n_tests++;
            if (o_div_clk[0] !== ((t % 4) < 2) || o_tick[0] !== ((t % 4) == 0) || o_busy[0] !== 1'b1)
            begin
                n_fail++;
                $display("FAIL basic_r4 t=%0d div=%b tick=%b busy=%b required %b %b 1", t,
                         o_div_clk[0], o_tick[0], o_busy[0], (t % 4) < 2, (t % 4) == 0);
            end
            n_tests++;
            if (o_div_clk !== exp_div || o_tick !== exp_tick || o_busy !== exp_busy) begin
                n_fail++;
                $display("FAIL basic_model t=%0d div=%b/%b tick=%b/%b busy=%b/%b", t,
                         o_div_clk, exp_div, o_tick, exp_tick, o_busy, exp_busy);
            end
        end
    endtask

    task automatic test_odd_ratios();
        int highs, ticks;
        do_reset();
        ratio[1*RW +: RW] = 8'd5;
        en[1] = 1'b1;
        highs = 0;
        for (int t = 0; t < 5; t++) begin
            cycle();
            if (o_div_clk[1]) highs++;
        end
        n_tests++;
        if (highs !== 3) begin
            n_fail++;
            $display("FAIL r5_high got=%0d required 3", highs);
        end
        do_reset();
        ratio[1*RW +: RW] = 8'd255;
        en[1] = 1'b1;
        highs = 0; ticks = 0;
        for (int t = 0; t < 255; t++) begin
            cycle();
            if (o_div_clk[1]) highs++;
            if (o_tick[1]) ticks++;
            n_tests++;
            if (o_div_clk !== exp_div || o_tick !== exp_tick || o_busy !== exp_busy) begin
                n_fail++;
                $display("FAIL r255_model t=%0d div=%b/%b tick=%b/%b busy=%b/%b", t,
                         o_div_clk, exp_div, o_tick, exp_tick, o_busy, exp_busy);
            end
        end
        cycle();
        n_tests++;
        if (highs !== 128 || ticks !== 1 || o_tick[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL r255_period highs=%0d ticks=%0d next_tick=%b required 128 1 1",
                     highs, ticks, o_tick[1]);
        end
    endtask

    task automatic test_ratio_change();
        int tq[$];
        do_reset();
        ratio[0*RW +: RW] = 8'd4;
        en[0] = 1'b1;
        for (int t = 0; t < 20; t++) begin
            cycle();
            if (o_tick[0]) tq.push_back(t);
            n_tests++;
            if (o_div_clk !== exp_div || o_tick !== exp_tick || o_busy !== exp_busy) begin
                n_fail++;
                $display("FAIL change_model t=%0d div=%b/%b tick=%b/%b busy=%b/%b", t,
                         o_div_clk, exp_div, o_tick, exp_tick, o_busy, exp_busy);
            end
            if (t == 1) ratio[0*RW +: RW] = 8'd6;
        end
        n_tests++;
        if (tq.size() != 4 || tq[0] != 0 || tq[1] != 4 || tq[2] != 10 || tq[3] != 16) begin
            n_fail++;
            $display("FAIL change_ticks count=%0d required ticks at 0,4,10,16", tq.size());
        end
    endtask

    task automatic test_disable();
        logic ediv, etick, ebusy;
        do_reset();
        ratio[2*RW +: RW] = 8'd6;
        en[2] = 1'b1;
        for (int t = 0; t < 12; t++) begin
            cycle();
            ediv  = (t < 3);
            etick = (t == 0);
            ebusy = (t < 6);
            n_tests++;
            if (o_div_clk[2] !== ediv || o_tick[2] !== etick || o_busy[2] !== ebusy) begin
                n_fail++;
                $display("FAIL disable t=%0d div=%b tick=%b busy=%b required %b %b %b", t,
                         o_div_clk[2], o_tick[2], o_busy[2], ediv, etick, ebusy);
            end
            if (t == 2) en[2] = 1'b0;
        end
    endtask

    task automatic test_bypass();
        do_reset();
        ratio[3*RW +: RW] = 8'd1;
        en[3] = 1'b1;
        for (int t = 0; t < 8; t++) begin
            if (t == 4) ratio[3*RW +: RW] = 8'd0;
            cycle();
            n_tests++;
            if (o_div_clk[3] !== 1'b1 || o_tick[3] !== 1'b1 || o_busy[3] !== 1'b1) begin
                n_fail++;
                $display("FAIL bypass_hi t=%0d div=%b tick=%b busy=%b required 1 1 1", t,
                         o_div_clk[3], o_tick[3], o_busy[3]);
            end
            @(negedge clk);
            #1;
            n_tests++;
            if (o_div_clk[3] !== 1'b0) begin
                n_fail++;
                $display("FAIL bypass_lo t=%0d div=%b required 0", t, o_div_clk[3]);
            end
        end
        ratio[3*RW +: RW] = 8'd3;
        for (int t = 0; t < 9; t++) begin
            cycle();
            n_tests++;
            if (o_div_clk[3] !== ((t % 3) < 2) || o_tick[3] !== ((t % 3) == 0)) begin
                n_fail++;
                $display("FAIL bypass_exit t=%0d div=%b tick=%b required %b %b", t,
                         o_div_clk[3], o_tick[3], (t % 3) < 2, (t % 3) == 0);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [NCH-1:0] rdiv[4];
        logic [NCH-1:0] rtick[4];
        rdiv  = '{4'hF, 4'h0, 4'h0, 4'hF};
        rtick = '{4'hF, 4'h0, 4'h0, 4'hF};
        do_reset();
        ratio = {4{8'd3}};
        mode  = 4'hF;
        en    = 4'hF;
        for (int t = 0; t < 4; t++) begin
            cycle();
            n_tests++;
            if (o_div_clk !== exp_div || o_tick !== exp_tick || o_busy !== exp_busy) begin
                n_fail++;
                $display("FAIL pulse_model t=%0d div=%b/%b tick=%b/%b busy=%b/%b", t,
                         o_div_clk, exp_div, o_tick, exp_tick, o_busy, exp_busy);
            end
        end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        n_tests++;
        if (o_div_clk !== 4'h0 || o_tick !== 4'h0 || o_busy !== 4'h0) begin
            n_fail++;
            $display("FAIL mid_reset div=%b tick=%b busy=%b required 0000", o_div_clk, o_tick, o_busy);
        end
        for (int t = 0; t < 4; t++) begin
            cycle();
            n_tests++;
            if (o_div_clk !== rdiv[t] || o_tick !== rtick[t] || o_busy !== 4'hF) begin
                n_fail++;
                $display("FAIL restart t=%0d div=%b tick=%b busy=%b required %b %b 1111", t,
                         o_div_clk, o_tick, o_busy, rdiv[t], rtick[t]);
            end
        end
    endtask

    task automatic test_random();
        int c;
        do_reset();
        for (int t = 0; t < 3000; t++) begin
            if ($urandom_range(0, 7) == 0) begin
                c = int'($urandom_range(0, NCH - 1));
                en[c]   = ($urandom_range(0, 5) != 0);
                mode[c] = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 19) == 0) ratio[c*RW +: RW] = 8'($urandom_range(13, 40));
                else                            ratio[c*RW +: RW] = 8'($urandom_range(0, 12));
            end
            rst = ($urandom_range(0, 299) == 0);
            cycle();
            n_tests++;
            if (o_div_clk !== exp_div || o_tick !== exp_tick || o_busy !== exp_busy) begin
                n_fail++;
                $display("FAIL random t=%0d div=%b/%b tick=%b/%b busy=%b/%b", t,
                         o_div_clk, exp_div, o_tick, exp_tick, o_busy, exp_busy);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = '0; mode = '0; ratio = '0;
        for (int c = 0; c < NCH; c++) begin
            m_act[c] = 0; m_byp[c] = 0; m_pos[c] = 0; m_len[c] = 0; m_hi[c] = 0;
        end
        test_reset();
        test_basic();
        test_odd_ratios();
        test_ratio_change();
        test_disable();
        test_bypass();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
